ccl_window_gen: RTL and testbench
=================================

# ccl_window_gen

Neighbourhood window generator that sits directly upstream of `connected_components_labeling`. It accepts a raster-order stream of thresholded pixels and presents each pixel `p` to the labeler, together with its already-labeled neighbours `A`, `B`, `C`, `D` and its coordinates `x`, `y`. It captures the labeler's output label `q` after a fixed pipeline latency and stores it in a one-row label line buffer, so that the window for the next pixel and the next row is always built from final per-pixel labels.

## Interface
- `WIDTH`, 640: image width in pixels, ≥ 2.
- `HEIGHT`, 480: image height in rows, ≥ 1.
- `WORD`, 8: label and pixel width; matches `WORD_SIZE`.
- `LABEL_LAT`, 2: cycles from `en` high to valid `q`, ≥ 1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `pix_valid`  in  1  upstream pixel available.
- `pix_ready`  out  1  block can accept a pixel.
- `pix_in`  in  WORD  pixel value; nonzero means foreground.
- `sof`  in  1  start-of-frame flag, qualified by `pix_valid & pix_ready`.
- `q`  in  WORD  label returned by the labeler.
- `en`  out  1  one-cycle strobe; window outputs are valid for the labeler.
- `A`, `B`, `C`, `D`  out  WORD each  neighbour labels.
- `p`  out  WORD  current pixel.
- `x`, `y`  out  16 each  coordinates of the current pixel.
- `frame_done`  out  1  one-cycle pulse after the label of the last pixel is captured.
- `sof_err`  out  1  one-cycle pulse when `sof` arrives mid-frame.

## Operation
- The FSM has four states:
  - IDLE: `pix_ready=1`. On handshake, go to ISSUE and register `pix_in` into `p`.
  - ISSUE: exactly one cycle with `en=1`. Go to WAIT, or go straight to CAPTURE when `LABEL_LAT=1`.
  - WAIT: held for `LABEL_LAT-1` cycles using a down-counter. Then go to CAPTURE.
  - CAPTURE: sample `q`, write `row_buf[x] <= q`, update the neighbour registers, advance `x`/`y`. Then go to IDLE.
- Window contents at pixel (x,y):
  - A = label(x-1, y-1)
  - B = label(x, y-1)
  - C = label(x+1, y-1)
  - D = label(x-1, y)
  - Any out-of-image neighbour is 0. This means: when y=0, A=B=C=0; when x=0, A=D=0; when x=WIDTH-1, C=0.
- Line buffer `row_buf` holds WIDTH entries of WORD bits. It is not reset; the y=0 masking makes its initial contents irrelevant.
- The old `row_buf[x]` value (previous row) must be preserved as the next pixel's A before it is overwritten by the current row's label. A sliding A/B/C register chain with a look-ahead read of `row_buf[x+1]` is the required structure.
- Counter advance happens in CAPTURE:
  - `x` increments.
  - At `x=WIDTH-1`, `x` wraps to 0 and `y` increments.
  - At (WIDTH-1, HEIGHT-1), both wrap to 0 and `frame_done` pulses in the following cycle.
- `sof` handling:
  - `sof` accepted while (x,y) = (0,0): normal.
  - `sof` accepted while (x,y) ≠ (0,0): `x`, `y`, `D` and the A/B/C chain are forced to frame-start values for that pixel, and `sof_err` pulses for one cycle.
- `D` is the `q` captured in the previous CAPTURE, masked to 0 at x=0.

## Timing
- Reset values:
  - state = IDLE
  - `pix_ready=1` from the first cycle after reset
  - `en`, `A`, `B`, `C`, `D`, `p`, `x`, `y`, `frame_done`, `sof_err` all 0
- Reset asserted in any state returns the FSM to IDLE on the next edge. An in-flight pixel is dropped, and no `row_buf` write occurs in that cycle.
- Per-pixel latency, with the handshake at cycle t:
  - `en` high at t+1.
  - `q` sampled at t+1+`LABEL_LAT`.
  - `pix_ready` high at t+2+`LABEL_LAT`.
- Throughput is one pixel per `LABEL_LAT+2` cycles.
- `A`, `B`, `C`, `D`, `p`, `x`, `y` are registered. They change only on the edge entering ISSUE and stay stable until the next ISSUE.
- `pix_valid` low in IDLE: the FSM stays in IDLE, `en` stays 0, and state is unchanged. `pix_ready` is 0 in every state other than IDLE.
- `q` is ignored in every cycle except CAPTURE.

## Test plan
- **Reset.** Hold `reset` for 2 cycles, then release. Require: all outputs 0; `pix_ready=1`; no `en` while `pix_valid=0`.
- **Single-pixel timing** (`LABEL_LAT=2`). Handshake at cycle 0 with `pix_in=1`. Require: `en=1` only at cycle 1 with p=1, x=0, y=0; `q=5` sampled at cycle 3; `pix_ready=1` at cycle 4; the next pixel sees D=5.
- **Window correctness** (WIDTH=4, HEIGHT=3). Use a model that returns label = 4y+x+1. Require:
  - (0,1): A=0, B=1, C=2, D=0
  - (2,1): A=2, B=3, C=4, D=6
  - (3,1): A=3, B=4, C=0, D=7
- **Frame wrap** (same configuration). After CAPTURE of (3,2), require: `frame_done` for exactly 1 cycle; the next pixel is issued at x=y=0 with A=B=C=D=0.
- **sof mid-frame.** Assert `sof` with the pixel that would be (1,1). Require: it is issued as (0,0) with A=B=C=D=0, and `sof_err` pulses once.
- **Reset mid-WAIT.** Assert `reset` in the cycle after `en`. Require: no `row_buf` write; `x` and `y` are 0; `pix_ready=1` the next cycle; a subsequent pixel is issued at (0,0).

Source files
------------

// File: rtl/ccl_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ccl_window_gen
//  Purpose  : Neighbourhood window generator for a connected-components
//             labeler. Accepts a raster-order pixel stream, presents each
//             pixel p with its already-labeled neighbours A (x-1,y-1),
//             B (x,y-1), C (x+1,y-1), D (x-1,y) and its coordinates, then
//             captures the labeler's label q LABEL_LAT cycles later into a
//             one-row line buffer.
//  Ports    :
//    clk, reset          clock, synchronous active-high reset
//    pix_valid/pix_ready upstream pixel handshake (ready only in IDLE)
//    pix_in, sof         pixel value and start-of-frame flag
//    q                   label returned by the labeler (sampled in CAPTURE)
//    en                  one-cycle strobe: window outputs valid
//    A, B, C, D, p       neighbour labels and current pixel
//    x, y                coordinates of the current pixel
//    frame_done          pulse after the last pixel's label is captured
//    sof_err             pulse when sof arrives mid-frame
//  Revision : 1.0 - initial release
// ============================================================================
module ccl_window_gen #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int WORD      = 8,
  parameter int LABEL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [WORD-1:0] pix_in,
  input  logic            sof,
  input  logic [WORD-1:0] q,
  output logic            en,
  output logic [WORD-1:0] A,
  output logic [WORD-1:0] B,
  output logic [WORD-1:0] C,
  output logic [WORD-1:0] D,
  output logic [WORD-1:0] p,
  output logic [15:0]     x,
  output logic [15:0]     y,
  output logic            frame_done,
  output logic            sof_err
);

  localparam int              XW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int              CW        = $clog2(LABEL_LAT + 1);
  localparam logic [15:0]     X_LAST    = 16'(WIDTH - 1);
  localparam logic [15:0]     Y_LAST    = 16'(HEIGHT - 1);
  localparam logic [CW-1:0]   WAIT_LOAD = CW'(LABEL_LAT - 1);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Registered window / coordinate outputs
  logic [WORD-1:0] a_q, b_q, c_q, d_q, p_q;
  logic [15:0]     x_q, y_q;
  // Coordinates the next accepted pixel will take
  logic [15:0]     nx_q, ny_q;
  // Label captured in the most recent CAPTURE (becomes D)
  logic [WORD-1:0] last_q_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            frame_done_q, sof_err_q;

  logic [WORD-1:0] row_buf [WIDTH];

  // --------------------------------------------------------------------------
  // Window build for the pixel being accepted this cycle
  // --------------------------------------------------------------------------
  logic            w_accept, w_restart;
  logic [15:0]     w_x, w_y;
  logic            w_first_row, w_first_col, w_last_col;
  logic [XW-1:0]   w_c_idx;
  logic [WORD-1:0] w_a, w_b, w_c, w_d;

  assign w_accept    = (state_q == S_IDLE) && pix_valid;
  // sof away from (0,0) restarts the frame on this very pixel
  assign w_restart   = sof && ((nx_q != 16'd0) || (ny_q != 16'd0));
  assign w_x         = w_restart ? 16'd0 : nx_q;
  assign w_y         = w_restart ? 16'd0 : ny_q;
  assign w_first_row = (w_y == 16'd0);
  assign w_first_col = (w_x == 16'd0);
  assign w_last_col  = (w_x == X_LAST);
  assign w_c_idx     = w_last_col ? '0 : XW'(w_x + 16'd1);

  // Sliding chain: the previous pixel's B/C already hold label(x-1,y-1) and
  // label(x,y-1), read before row_buf[x-1] was overwritten by the current
  // row. Only C needs a fresh look-ahead read. At x=0 the chain carries the
  // end of the previous row, so B is read directly from row_buf[0].
  assign w_a = (w_first_row || w_first_col) ? '0 : b_q;
  assign w_b = w_first_row ? '0 : (w_first_col ? row_buf[0] : c_q);
  assign w_c = (w_first_row || w_last_col) ? '0 : row_buf[w_c_idx];
  assign w_d = w_first_col ? '0 : last_q_q;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pix_valid) state_d = S_ISSUE;
      S_ISSUE:   state_d = (LABEL_LAT == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (wait_cnt_q == WAIT_LAST) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      p_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      last_q_q     <= '0;
      wait_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;

      if (w_accept) begin
        p_q       <= pix_in;
        x_q       <= w_x;
        y_q       <= w_y;
        a_q       <= w_a;
        b_q       <= w_b;
        c_q       <= w_c;
        d_q       <= w_d;
        sof_err_q <= w_restart;
      end

      if (state_q == S_ISSUE)     wait_cnt_q <= WAIT_LOAD;
      else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q - CW'(1);

      if (state_q == S_CAPTURE) begin
        last_q_q <= q;
        if (x_q == X_LAST) begin
          nx_q <= '0;
          if (y_q == Y_LAST) begin
            ny_q         <= '0;
            frame_done_q <= 1'b1;
          end else begin
            ny_q <= y_q + 16'd1;
          end
        end else begin
          nx_q <= x_q + 16'd1;
          ny_q <= y_q;
        end
      end
    end
  end

  // Line buffer: no reset, first-row masking hides its initial contents
  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_CAPTURE)) row_buf[x_q[XW-1:0]] <= q;
  end

  assign pix_ready  = (state_q == S_IDLE);
  assign en         = (state_q == S_ISSUE);
  assign A          = a_q;
  assign B          = b_q;
  assign C          = c_q;
  assign D          = d_q;
  assign p          = p_q;
  assign x          = x_q;
  assign y          = y_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ccl_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccl_window_gen
//  Purpose  : Self-checking bench for ccl_window_gen (4x3 image, LABEL_LAT=2).
//             The bench plays the labeler and keeps a label image of every
//             captured pixel; expected windows are looked up from that image.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ccl_window_gen;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] pix_in = '0;
  logic       sof = 1'b0;
  logic [7:0] q = '0;
  logic       en;
  logic [7:0] A, B, C, D, p;
  logic [15:0] x, y;
  logic       frame_done, sof_err;

  int ntests = 0;
  int nfail  = 0;

  // Reference state: label image and next raster position
  int mlab [H][W];
  int mx = 0;
  int my = 0;
  // Window seen at the latest en strobe
  int lA, lB, lC, lD, lx, ly, lerr;

  always #5 clk = ~clk;

  ccl_window_gen #(.WIDTH(W), .HEIGHT(H), .WORD(8), .LABEL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_in(pix_in), .sof(sof), .q(q), .en(en),
    .A(A), .B(B), .C(C), .D(D), .p(p), .x(x), .y(y),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_en", en, 0);
      check("idle_ready", pix_ready, 1);
      check("idle_frame_done", frame_done, 0);
      check("idle_sof_err", sof_err, 0);
    end
  endtask

  // One full pixel transaction; lab is returned as q only in the capture cycle
  task automatic send_pixel(input logic [7:0] pin, input logic s, input logic [7:0] lab);
    int eA, eB, eC, eD, eerr, last;
    eerr = (s && (mx != 0 || my != 0)) ? 1 : 0;
    if (s) begin mx = 0; my = 0; end
    eA = (mx > 0 && my > 0) ? mlab[my-1][mx-1] : 0;
    eB = (my > 0) ? mlab[my-1][mx] : 0;
    eC = (my > 0 && mx < W-1) ? mlab[my-1][mx+1] : 0;
    eD = (mx > 0) ? mlab[my][mx-1] : 0;
    last = (mx == W-1 && my == H-1) ? 1 : 0;

    check("ready_before", pix_ready, 1);
    pix_valid = 1'b1; pix_in = pin; sof = s;
    tick();
    pix_valid = 1'b0; sof = 1'b0; pix_in = 8'($urandom_range(0, 255));
    check("issue_en", en, 1);
    check("issue_p", p, pin);
    check("issue_x", x, mx);
    check("issue_y", y, my);
    check("win_A", A, eA);
    check("win_B", B, eB);
    check("win_C", C, eC);
    check("win_D", D, eD);
    check("issue_sof_err", sof_err, eerr);
    check("issue_frame_done", frame_done, 0);
    check("issue_ready", pix_ready, 0);
    lA = A; lB = B; lC = C; lD = D; lx = x; ly = y; lerr = sof_err;
    q = 8'($urandom_range(0, 255));
    for (int k = 1; k < LAT; k++) begin
      tick();
      check("wait_en", en, 0);
      check("wait_ready", pix_ready, 0);
      check("wait_sof_err", sof_err, 0);
      q = 8'($urandom_range(0, 255));
    end
    tick();
    q = lab;
    check("capture_en", en, 0);
    check("capture_ready", pix_ready, 0);
    tick();
    q = 8'($urandom_range(0, 255));
    check("done_ready", pix_ready, 1);
    check("done_en", en, 0);
    check("frame_done", frame_done, last);
    check("stable_x", x, mx);

    mlab[my][mx] = lab;
    if (mx == W-1) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  initial begin
    // Reset for two cycles
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_en", en, 0);
      check("rst_ready", pix_ready, 1);
      check("rst_A", A, 0);
      check("rst_B", B, 0);
      check("rst_C", C, 0);
      check("rst_D", D, 0);
      check("rst_p", p, 0);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_sof_err", sof_err, 0);
    end
    reset = 1'b0;
    idle_ticks(3);

    // Single-pixel timing: label 5 must appear as the next pixel's D
    send_pixel(8'd1, 1'b1, 8'd5);
    send_pixel(8'd2, 1'b0, 8'd9);
    check("single_D", lD, 5);

    // Reset in the cycle after en
    check("rw_ready", pix_ready, 1);
    pix_valid = 1'b1; pix_in = 8'h33;
    tick();
    pix_valid = 1'b0;
    check("rw_en", en, 1);
    check("rw_x", x, 2);
    tick();
    check("rw_wait_en", en, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rw_x0", x, 0);
    check("rw_y0", y, 0);
    check("rw_ready_after", pix_ready, 1);
    check("rw_en_after", en, 0);
    mx = 0; my = 0;
    idle_ticks(1);

    // Full frame with label = 4y+x+1
    for (int i = 0; i < W*H; i++) begin
      send_pixel(8'($urandom_range(0, 255)), (i == 0), 8'(4*(i/W) + (i%W) + 1));
      if (i == 0) begin
        check("restart_x", lx, 0);
        check("restart_y", ly, 0);
      end
      if (i == 4) begin
        check("w01_A", lA, 0); check("w01_B", lB, 1);
        check("w01_C", lC, 2); check("w01_D", lD, 0);
      end
      if (i == 6) begin
        check("w21_A", lA, 2); check("w21_B", lB, 3);
        check("w21_C", lC, 4); check("w21_D", lD, 6);
      end
      if (i == 7) begin
        check("w31_A", lA, 3); check("w31_B", lB, 4);
        check("w31_C", lC, 0); check("w31_D", lD, 7);
      end
    end
    idle_ticks(1);

    // Frame wrap, then sof on the pixel that would be (1,1)
    for (int i = 0; i < 5; i++) begin
      send_pixel(8'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(1, 255)));
      if (i == 0) begin
        check("wrap_x", lx, 0); check("wrap_y", ly, 0);
        check("wrap_A", lA, 0); check("wrap_B", lB, 0);
        check("wrap_C", lC, 0); check("wrap_D", lD, 0);
      end
    end
    send_pixel(8'd7, 1'b1, 8'($urandom_range(1, 255)));
    check("sof_x", lx, 0);
    check("sof_y", ly, 0);
    check("sof_A", lA, 0);
    check("sof_B", lB, 0);
    check("sof_C", lC, 0);
    check("sof_D", lD, 0);
    check("sof_err_pulse", lerr, 1);
    idle_ticks(1);

    // Randomized traffic: random labels, gaps and occasional sof
    for (int i = 0; i < 60; i++) begin
      send_pixel(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0),
                 8'($urandom_range(0, 255)));
      idle_ticks(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
